// File: rtl/poly_dds.sv
// poly_dds: bank of note-driven phase accumulators (polyphonic DDS).
// A note request is turned into a phase increment by a short octave-
// reduction loop, then loaded into one channel; every channel accumulates
// its current increment on every clock edge.
// Optional build macro POLY_DDS_GLIDE_EN adds glide (portamento) on legato
// note-on; without it the new increment takes effect immediately.
module poly_dds #(
    parameter int  CHANNELS    = 4,
    parameter int  PHASE_W     = 32,
    parameter int  GLIDE_SHIFT = 4,
    localparam int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        NOTE_VALID,
    output logic                        NOTE_READY,
    input  logic [CW-1:0]               NOTE_CHAN,
    input  logic [7:0]                  NOTE,
    input  logic                        GATE,
    output logic [CHANNELS*PHASE_W-1:0] PHASE,
    output logic [CHANNELS-1:0]         ACTIVE,
    output logic                        NOTE_ERR
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_LOAD = 2'd2;

    if (CHANNELS < 1 || CHANNELS > 16 || PHASE_W < 32 || PHASE_W > 48 ||
        GLIDE_SHIFT < 1 || GLIDE_SHIFT > 8) begin : g_param_check
        $error("poly_dds: parameter out of legal range");
    end

    // Top-octave (octave 13) increments for the twelve semitones, 32-bit scale.
    function automatic logic [15:0] base_inc(input logic [3:0] semi);
        case (semi)
            4'd0:    base_inc = 16'd22473;
            4'd1:    base_inc = 16'd23809;
            4'd2:    base_inc = 16'd25225;
            4'd3:    base_inc = 16'd26725;
            4'd4:    base_inc = 16'd28314;
            4'd5:    base_inc = 16'd29998;
            4'd6:    base_inc = 16'd31782;
            4'd7:    base_inc = 16'd33672;
            4'd8:    base_inc = 16'd35674;
            4'd9:    base_inc = 16'd37795;
            4'd10:   base_inc = 16'd40043;
            4'd11:   base_inc = 16'd42424;
            default: base_inc = 16'd0;
        endcase
    endfunction

    // Scale the base to the accumulator width, then divide down by octave (truncating).
    function automatic logic [PHASE_W-1:0] note_inc(input logic [3:0] semi, input logic [3:0] oct);
        logic [PHASE_W-1:0] scaled;
        scaled   = {{(PHASE_W-16){1'b0}}, base_inc(semi)} << (PHASE_W - 32);
        note_inc = scaled >> (4'd13 - oct);
    endfunction

`ifdef POLY_DDS_GLIDE_EN
    // One glide step: move by 1/2^GLIDE_SHIFT of the gap, snap when the gap is small.
    function automatic logic [PHASE_W-1:0] glide_next(input logic [PHASE_W-1:0] cur,
                                                      input logic [PHASE_W-1:0] tgt);
        logic signed [PHASE_W:0] diff;
        logic signed [PHASE_W:0] mag;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        mag  = diff[PHASE_W] ? -diff : diff;
        if (mag < (PHASE_W+1)'(2 ** GLIDE_SHIFT))
            glide_next = tgt;
        else
            glide_next = cur + PHASE_W'(diff >>> GLIDE_SHIFT);
    endfunction
`endif

    logic [1:0]          r_state;
    logic [CW-1:0]       r_chan;
    logic [7:0]          r_rem;
    logic [3:0]          r_oct;
    logic                r_gate;
    logic                r_err;
    logic [PHASE_W-1:0]  r_phase [CHANNELS];
    logic [PHASE_W-1:0]  r_cur   [CHANNELS];
`ifdef POLY_DDS_GLIDE_EN
    logic [PHASE_W-1:0]  r_tgt   [CHANNELS];
`endif
    logic [CHANNELS-1:0] r_active;

    logic                w_accept;
    logic                w_reject;
    logic                w_load;
    logic [PHASE_W-1:0]  w_inc;

    assign w_accept = NOTE_VALID && (r_state == S_IDLE);
    assign w_reject = ({1'b0, NOTE_CHAN} >= (CW+1)'(CHANNELS)) || (GATE && (NOTE > 8'd167));
    assign w_load   = (r_state == S_LOAD);
    assign w_inc    = note_inc(r_rem[3:0], r_oct);

    // Request FSM: capture, reduce note to (octave, semitone), then load one channel.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_chan  <= '0;
            r_rem   <= '0;
            r_oct   <= '0;
            r_gate  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_reject) begin
                            r_err <= 1'b1;
                        end else begin
                            r_chan  <= NOTE_CHAN;
                            r_rem   <= NOTE;
                            r_oct   <= '0;
                            r_gate  <= GATE;
                            r_state <= GATE ? S_CALC : S_LOAD;
                        end
                    end
                end
                S_CALC: begin
                    if (r_rem >= 8'd12) begin
                        r_rem <= r_rem - 8'd12;
                        r_oct <= r_oct + 4'd1;
                    end else begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Per-channel accumulators; the LOAD edge rewrites only the addressed channel.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_phase[i] <= '0;
                r_cur[i]   <= '0;
`ifdef POLY_DDS_GLIDE_EN
                r_tgt[i]   <= '0;
`endif
            end
            r_active <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_phase[i] <= r_phase[i] + r_cur[i];
`ifdef POLY_DDS_GLIDE_EN
                r_cur[i]   <= glide_next(r_cur[i], r_tgt[i]);
`endif
                if (w_load && (r_chan == CW'(i))) begin
                    if (r_gate) begin
                        r_active[i] <= 1'b1;
                        // A fresh note restarts its waveform; legato keeps phase continuity.
                        if (!r_active[i])
                            r_phase[i] <= '0;
`ifdef POLY_DDS_GLIDE_EN
                        r_tgt[i] <= w_inc;
                        if (!r_active[i])
                            r_cur[i] <= w_inc;
                        else
                            r_cur[i] <= r_cur[i];
`else
                        r_cur[i] <= w_inc;
`endif
                    end else begin
                        r_active[i] <= 1'b0;
                        r_cur[i]    <= '0;
`ifdef POLY_DDS_GLIDE_EN
                        r_tgt[i]    <= '0;
`endif
                    end
                end
            end
        end
    end

    // Pack channel accumulators onto the flat output bus.
    always_comb begin
        PHASE = '0;
        for (int i = 0; i < CHANNELS; i++)
            PHASE[i*PHASE_W +: PHASE_W] = r_phase[i];
    end

    assign NOTE_READY = (r_state == S_IDLE);
    assign ACTIVE     = r_active;
    assign NOTE_ERR   = r_err;

endmodule

// File: tb/tb_poly_dds.sv
// tb_poly_dds: randomized self-checking bench for poly_dds with a
// cycle-level behavioural model (request -> load edge -> per-edge accumulate).
`timescale 1ns/1ps
module tb_poly_dds;
    localparam int CH = 4;
    localparam int PW = 32;
    localparam int GS = 4;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          NOTE_VALID = 1'b0;
    logic          NOTE_READY;
    logic [1:0]    NOTE_CHAN = '0;
    logic [7:0]    NOTE = '0;
    logic          GATE = 1'b0;
    logic [CH*PW-1:0] PHASE;
    logic [CH-1:0] ACTIVE;
    logic          NOTE_ERR;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    poly_dds #(.CHANNELS(CH), .PHASE_W(PW), .GLIDE_SHIFT(GS)) dut (
        .CLK(CLK), .RESET(RESET), .NOTE_VALID(NOTE_VALID), .NOTE_READY(NOTE_READY),
        .NOTE_CHAN(NOTE_CHAN), .NOTE(NOTE), .GATE(GATE), .PHASE(PHASE),
        .ACTIVE(ACTIVE), .NOTE_ERR(NOTE_ERR)
    );

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_ph  [CH];
    longint      m_cur [CH];
    longint      m_tgt [CH];
    bit          m_act [CH];
    longint      cyc = 0;
    bit          pend = 0;
    longint      pend_edge;
    int          pend_ch;
    bit          pend_gate;
    longint      pend_inc;

    // Frequency word for a note: top-octave base for its semitone halved once per octave below 13.
    function automatic longint ref_inc(input int n);
        int base [12];
        base = '{22473, 23809, 25225, 26725, 28314, 29998, 31782, 33672, 35674, 37795, 40043, 42424};
        return longint'(base[n % 12]) >> (13 - n / 12);
    endfunction

    function automatic logic [3:0] m_act_vec();
        logic [3:0] v;
        for (int c = 0; c < CH; c++) v[c] = m_act[c];
        return v;
    endfunction

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int c = 0; c < CH; c++) begin
                m_ph[c] = '0; m_cur[c] = 0; m_tgt[c] = 0; m_act[c] = 0;
            end
            pend = 0;
        end else begin
            cyc++;
            for (int c = 0; c < CH; c++) begin
                longint d;
                m_ph[c] = m_ph[c] + 32'(m_cur[c]);
`ifdef POLY_DDS_GLIDE_EN
                if (!(pend && cyc == pend_edge && c == pend_ch)) begin
                    d = m_tgt[c] - m_cur[c];
                    if (d < (1 << GS) && d > -(1 << GS)) m_cur[c] = m_tgt[c];
                    else m_cur[c] = m_cur[c] + (d >>> GS);
                end
`else
                d = 0;
`endif
            end
            if (pend && cyc == pend_edge) begin
                if (pend_gate) begin
                    if (!m_act[pend_ch]) begin
                        m_ph[pend_ch]  = '0;
                        m_cur[pend_ch] = pend_inc;
                    end
`ifndef POLY_DDS_GLIDE_EN
                    m_cur[pend_ch] = pend_inc;
`endif
                    m_tgt[pend_ch] = pend_inc;
                    m_act[pend_ch] = 1;
                end else begin
                    m_tgt[pend_ch] = 0; m_cur[pend_ch] = 0; m_act[pend_ch] = 0;
                end
                pend = 0;
            end
        end
    end

    // Issue one request once the block is ready; returns #1 after the accepting edge.
    task automatic send(input int ch, input int n, input bit g);
        int w;
        w = 0;
        @(negedge CLK);
        while (NOTE_READY !== 1'b1 && w < 100) begin @(negedge CLK); w++; end
        if (w >= 100) begin
            checks++; failures++;
            $display("FAIL send_ready_timeout: ready=%b required 1", NOTE_READY);
            return;
        end
        NOTE_CHAN = ch[1:0]; NOTE = n[7:0]; GATE = g; NOTE_VALID = 1'b1;
        if (!(g && n > 167)) begin
            pend_ch = ch; pend_gate = g; pend_inc = g ? ref_inc(n) : 0;
            pend_edge = cyc + 1 + (g ? (n / 12 + 2) : 1);
            pend = 1;
        end
        @(posedge CLK); #1;
        NOTE_VALID = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if (PHASE !== '0) begin failures++; $display("FAIL reset_phase_during: got %h required 0", PHASE); end
        checks++;
        if (NOTE_READY !== 1'b1) begin failures++; $display("FAIL reset_ready_during: got %b required 1", NOTE_READY); end
        RESET = 1'b0;
        @(negedge CLK);
        checks++;
        if (ACTIVE !== '0) begin failures++; $display("FAIL reset_active: got %b required 0", ACTIVE); end
        checks++;
        if (NOTE_ERR !== 1'b0) begin failures++; $display("FAIL reset_err: got %b required 0", NOTE_ERR); end
        checks++;
        if (PHASE !== '0) begin failures++; $display("FAIL reset_phase_after: got %h required 0", PHASE); end
    endtask

    task automatic test_note_on_latency();
        int cnt;
        logic [31:0] p0, p1;
        send(0, 69, 1);
        cnt = 0;
        @(negedge CLK);
        while (NOTE_READY === 1'b0 && cnt < 50) begin cnt++; @(negedge CLK); end
        // 69 = octave 5 + semitone 9: five reductions, one exit cycle, one load cycle.
        checks++;
        if (cnt != 69 / 12 + 2) begin failures++; $display("FAIL busy_cycles: got %0d required %0d", cnt, 69 / 12 + 2); end
        checks++;
        if (PHASE[0 +: 32] !== 32'd0) begin failures++; $display("FAIL ch0_start: got %0d required 0", PHASE[0 +: 32]); end
        for (int k = 0; k < 3; k++) begin
            p0 = PHASE[0 +: 32];
            @(negedge CLK);
            p1 = PHASE[0 +: 32];
            checks++;
            if (p1 - p0 !== 32'(ref_inc(69))) begin
                failures++; $display("FAIL ch0_step69: got %0d required %0d", p1 - p0, ref_inc(69));
            end
        end
        checks++;
        if (ACTIVE !== 4'b0001) begin failures++; $display("FAIL active_after69: got %b required 0001", ACTIVE); end
    endtask

    task automatic test_multi_channel();
        logic [31:0] p0;
        send(1, 0, 1);
        send(2, 167, 1);
        repeat (20) @(negedge CLK);
        p0 = PHASE[64 +: 32];
        @(negedge CLK);
        checks++;
        if (PHASE[64 +: 32] - p0 !== 32'(ref_inc(167))) begin
            failures++; $display("FAIL ch2_step: got %0d required %0d", PHASE[64 +: 32] - p0, ref_inc(167));
        end
        for (int c = 0; c < CH; c++) begin
            checks++;
            if (PHASE[c*PW +: PW] !== m_ph[c]) begin
                failures++; $display("FAIL multi_phase ch%0d: got %0d required %0d", c, PHASE[c*PW +: PW], m_ph[c]);
            end
        end
    endtask

    task automatic test_bad_note();
        send(3, 168, 1);
        @(negedge CLK);
        checks++;
        if (NOTE_ERR !== 1'b1) begin failures++; $display("FAIL err_pulse: got %b required 1", NOTE_ERR); end
        @(negedge CLK);
        checks++;
        if (NOTE_ERR !== 1'b0) begin failures++; $display("FAIL err_one_cycle: got %b required 0", NOTE_ERR); end
        checks++;
        if (ACTIVE[3] !== 1'b0) begin failures++; $display("FAIL err_active3: got %b required 0", ACTIVE[3]); end
        checks++;
        if (PHASE[96 +: 32] !== 32'd0) begin failures++; $display("FAIL err_phase3: got %0d required 0", PHASE[96 +: 32]); end
        checks++;
        if (NOTE_READY !== 1'b1) begin failures++; $display("FAIL err_ready: got %b required 1", NOTE_READY); end
    endtask

    task automatic test_note_off_restart();
        logic [31:0] frozen;
        int cnt;
        send(0, 0, 0);
        repeat (2) @(negedge CLK);
        checks++;
        if (ACTIVE[0] !== 1'b0) begin failures++; $display("FAIL off_active0: got %b required 0", ACTIVE[0]); end
        frozen = PHASE[0 +: 32];
        repeat (6) @(negedge CLK);
        checks++;
        if (PHASE[0 +: 32] !== frozen) begin failures++; $display("FAIL off_frozen: got %0d required %0d", PHASE[0 +: 32], frozen); end
        checks++;
        if (PHASE[0 +: 32] !== m_ph[0]) begin failures++; $display("FAIL off_model: got %0d required %0d", PHASE[0 +: 32], m_ph[0]); end
        send(0, 60, 1);
        cnt = 0;
        @(negedge CLK);
        while (NOTE_READY === 1'b0 && cnt < 50) begin cnt++; @(negedge CLK); end
        checks++;
        if (PHASE[0 +: 32] !== 32'd0) begin failures++; $display("FAIL restart_zero: got %0d required 0", PHASE[0 +: 32]); end
        repeat (2) @(negedge CLK);
        checks++;
        if (PHASE[0 +: 32] !== 32'(2 * ref_inc(60))) begin
            failures++; $display("FAIL restart_step60: got %0d required %0d", PHASE[0 +: 32], 2 * ref_inc(60));
        end
    endtask

    task automatic test_reset_abort();
        send(0, 100, 1);
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        checks++;
        if (PHASE !== '0) begin failures++; $display("FAIL abort_phase: got %h required 0", PHASE); end
        checks++;
        if (ACTIVE !== '0) begin failures++; $display("FAIL abort_active: got %b required 0", ACTIVE); end
        checks++;
        if (NOTE_READY !== 1'b1) begin failures++; $display("FAIL abort_ready: got %b required 1", NOTE_READY); end
        repeat (15) @(negedge CLK);
        checks++;
        if (PHASE !== '0 || ACTIVE !== '0) begin
            failures++; $display("FAIL abort_no_effect: phase=%h active=%b required all 0", PHASE, ACTIVE);
        end
    endtask

    task automatic test_random();
        int ch, n, w;
        bit g;
        for (int k = 0; k < 30; k++) begin
            ch = $urandom_range(0, 3);
            n  = $urandom_range(0, 175);
            g  = ($urandom_range(0, 3) != 0);
            send(ch, n, g);
            @(negedge CLK);
            checks++;
            if (NOTE_ERR !== 1'(g && n > 167)) begin
                failures++; $display("FAIL rnd_err k=%0d: got %b required %b", k, NOTE_ERR, (g && n > 167));
            end
            w = $urandom_range(0, 25);
            repeat (w) @(negedge CLK);
            for (int c = 0; c < CH; c++) begin
                checks++;
                if (PHASE[c*PW +: PW] !== m_ph[c]) begin
                    failures++; $display("FAIL rnd_phase k=%0d ch%0d: got %0d required %0d", k, c, PHASE[c*PW +: PW], m_ph[c]);
                end
            end
            checks++;
            if (ACTIVE !== m_act_vec()) begin
                failures++; $display("FAIL rnd_active k=%0d: got %b required %b", k, ACTIVE, m_act_vec());
            end
        end
    endtask

`ifdef POLY_DDS_GLIDE_EN
    task automatic test_glide();
        logic [31:0] p0, d, prev;
        bit mono, reached;
        int cnt;
        RESET = 1'b1; @(negedge CLK); RESET = 1'b0;
        send(0, 144, 1);
        send(0, 156, 1);
        cnt = 0;
        @(negedge CLK);
        while (NOTE_READY === 1'b0 && cnt < 50) begin cnt++; @(negedge CLK); end
        prev = 32'(ref_inc(144)); mono = 1; reached = 0;
        for (int k = 0; k < 200 && !reached; k++) begin
            p0 = PHASE[0 +: 32];
            @(negedge CLK);
            d = PHASE[0 +: 32] - p0;
            if (d < prev) mono = 0;
            prev = d;
            if (d == 32'(ref_inc(156))) reached = 1;
        end
        checks++;
        if (!mono) begin failures++; $display("FAIL glide_monotonic: got 0 required 1"); end
        checks++;
        if (!reached) begin failures++; $display("FAIL glide_reach: last step %0d required %0d", prev, ref_inc(156)); end
        checks++;
        if (PHASE[0 +: 32] !== m_ph[0]) begin failures++; $display("FAIL glide_model: got %0d required %0d", PHASE[0 +: 32], m_ph[0]); end
    endtask
`endif

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_note_on_latency();
        test_multi_channel();
        test_bad_note();
        test_note_off_restart();
        test_reset_abort();
        test_random();
`ifdef POLY_DDS_GLIDE_EN
        test_glide();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
